// File: rtl/alu_op_driver_if.sv
// ALU operand driver command/response bundle.
//   cmd_*  : command channel (valid/ready), a/b operands, select, expected result
//   rsp_*  : response channel (valid/ready), captured result, select, mismatch flag
// master : the sequencer/bench side that issues commands and consumes responses.
// slave  : the driver side that accepts commands and produces responses.
interface alu_op_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_sel;
  logic [4:0] cmd_exp;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_data;
  logic [2:0] rsp_sel;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_exp, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_sel, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_exp, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_sel, rsp_err
  );
endinterface

// File: rtl/alu_op_driver.sv
// Initiator side of the ALU operand interface.
// Queues ALU commands in a DEPTH-entry FIFO, drives them one at a time onto alu_a/alu_b/alu_sel,
// waits SETTLE cycles, captures alu_out and returns it on the response channel.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       cmd_* command channel in, rsp_* response channel out
//   alu_a/b/sel       operands and select driven to the combinational ALU
//   alu_out           ALU result sampled at the end of the settle window
//   busy              an op is in flight or commands are queued
//   op_count          completed responses, wraps 255 -> 0
//
// Optional build macro ALU_DRV_CHECK_EN: stores cmd_exp with each command and flags
// rsp_err when the captured result differs from it. Without it rsp_err is tied 0.
module alu_op_driver #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_op_driver_if.slave bus,
  output logic [3:0]     alu_a,
  output logic [3:0]     alu_b,
  output logic [2:0]     alu_sel,
  input  logic [4:0]     alu_out,
  output logic           busy,
  output logic [7:0]     op_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

`ifdef ALU_DRV_CHECK_EN
  typedef struct packed {
    logic [4:0] exp;
    logic [2:0] sel;
    logic [3:0] b;
    logic [3:0] a;
  } entry_t;
`else
  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] b;
    logic [3:0] a;
  } entry_t;
`endif

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [3:0]        settle_q, settle_d;
  logic [3:0]        alu_a_q, alu_a_d;
  logic [3:0]        alu_b_q, alu_b_d;
  logic [2:0]        alu_sel_q, alu_sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [4:0]        rsp_data_q, rsp_data_d;
  logic [2:0]        rsp_sel_q, rsp_sel_d;
  logic [7:0]        op_count_q, op_count_d;
`ifdef ALU_DRV_CHECK_EN
  logic [4:0]        exp_q, exp_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  entry_t            mem_q [DEPTH];
  entry_t            wr_entry;
  entry_t            rd_entry;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // No bypass: a pop in the same cycle does not open a slot for a push.
  assign push  = bus.cmd_valid && !full;

  always_comb begin
    wr_entry     = '0;
    wr_entry.a   = bus.cmd_a;
    wr_entry.b   = bus.cmd_b;
    wr_entry.sel = bus.cmd_sel;
`ifdef ALU_DRV_CHECK_EN
    wr_entry.exp = bus.cmd_exp;
`endif
  end

`ifndef ALU_DRV_CHECK_EN
  logic unused_cmd_exp;
  assign unused_cmd_exp = ^bus.cmd_exp;
`endif

  assign rd_entry = mem_q[rd_ptr_q];

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_sel_d   = rsp_sel_q;
    op_count_d  = op_count_q;
    pop         = 1'b0;
`ifdef ALU_DRV_CHECK_EN
    exp_d       = exp_q;
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop       = 1'b1;
          alu_a_d   = rd_entry.a;
          alu_b_d   = rd_entry.b;
          alu_sel_d = rd_entry.sel;
`ifdef ALU_DRV_CHECK_EN
          exp_d     = rd_entry.exp;
`endif
          settle_d  = 4'(SETTLE - 1);
          state_d   = StDrive;
        end
      end
      StDrive: begin
        if (settle_q == 4'd0) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_out;
          rsp_sel_d   = alu_sel_q;
`ifdef ALU_DRV_CHECK_EN
          rsp_err_d   = (alu_out != exp_q);
`endif
          state_d     = StResp;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef ALU_DRV_CHECK_EN
          rsp_err_d   = 1'b0;
`endif
          op_count_d  = op_count_q + 8'd1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      settle_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sel_q   <= '0;
      op_count_q  <= '0;
`ifdef ALU_DRV_CHECK_EN
      exp_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      settle_q    <= settle_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sel_q   <= rsp_sel_d;
      op_count_q  <= op_count_d;
`ifdef ALU_DRV_CHECK_EN
      exp_q       <= exp_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_sel   = rsp_sel_q;
`ifdef ALU_DRV_CHECK_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_sel  = alu_sel_q;
  assign busy     = (state_q != StIdle) || !empty;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: a DEPTH=4/SETTLE=1 instance checked every cycle against a
// command-queue model, plus a SETTLE=3 instance for the latency test.
module tb_alu_op_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_driver_if bus1 ();
  alu_op_driver_if bus3 ();

  logic [3:0] alu_a1, alu_b1, alu_a3, alu_b3;
  logic [2:0] alu_sel1, alu_sel3;
  logic [4:0] alu_out1, alu_out3;
  logic       busy1, busy3;
  logic [7:0] opc1, opc3;

  // Team ALU: 5-bit result, sel 0 = add.
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel);
    case (sel)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a, 1'b0};
      default: return {1'b0, b};
    endcase
  endfunction

  assign alu_out1 = alu_fn(alu_a1, alu_b1, alu_sel1);
  assign alu_out3 = alu_fn(alu_a3, alu_b3, alu_sel3);

  alu_op_driver #(.DEPTH(4), .SETTLE(1)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus1),
    .alu_a    (alu_a1),
    .alu_b    (alu_b1),
    .alu_sel  (alu_sel1),
    .alu_out  (alu_out1),
    .busy     (busy1),
    .op_count (opc1)
  );

  alu_op_driver #(.DEPTH(4), .SETTLE(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus3),
    .alu_a    (alu_a3),
    .alu_b    (alu_b3),
    .alu_sel  (alu_sel3),
    .alu_out  (alu_out3),
    .busy     (busy3),
    .op_count (opc3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: accepted-but-unanswered commands in order, and completed handshakes.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [4:0] exp;
  } cmd_t;

  cmd_t       mq[$];
  int         hs_cnt = 0;
  cmd_t       front;
  logic [4:0] m_data;
  logic       m_err;
  cmd_t       nc;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      hs_cnt = 0;
      chk("rst_cmd_ready", bus1.cmd_ready, 1);
      chk("rst_rsp_valid", bus1.rsp_valid, 0);
      chk("rst_rsp_data", bus1.rsp_data, 0);
      chk("rst_rsp_sel", bus1.rsp_sel, 0);
      chk("rst_rsp_err", bus1.rsp_err, 0);
      chk("rst_alu_a", alu_a1, 0);
      chk("rst_alu_b", alu_b1, 0);
      chk("rst_alu_sel", alu_sel1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_op_count", opc1, 0);
    end else begin
      chk("op_count", opc1, hs_cnt[7:0]);
      if (bus1.rsp_valid) begin
        chk("rsp_has_cmd", (mq.size() > 0), 1);
        if (mq.size() > 0) begin
          front  = mq[0];
          m_data = alu_fn(front.a, front.b, front.sel);
`ifdef ALU_DRV_CHECK_EN
          m_err  = (m_data != front.exp);
`else
          m_err  = 1'b0;
`endif
          chk("rsp_data", bus1.rsp_data, m_data);
          chk("rsp_sel", bus1.rsp_sel, front.sel);
          chk("rsp_err", bus1.rsp_err, m_err);
          if (bus1.rsp_ready) begin
            void'(mq.pop_front());
            hs_cnt++;
          end
        end
      end else begin
        chk("rsp_err_idle", bus1.rsp_err, 0);
      end
      if (bus1.cmd_valid && bus1.cmd_ready) begin
        nc.a   = bus1.cmd_a;
        nc.b   = bus1.cmd_b;
        nc.sel = bus1.cmd_sel;
        nc.exp = bus1.cmd_exp;
        mq.push_back(nc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                       input logic [4:0] exp);
    bus1.cmd_a     = a;
    bus1.cmd_b     = b;
    bus1.cmd_sel   = sel;
    bus1.cmd_exp   = exp;
    bus1.cmd_valid = 1'b1;
    step();
    bus1.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp1(input string name);
    int k;
    k = 0;
    while (!bus1.rsp_valid && k < 20) begin
      step();
      k++;
    end
    chk(name, bus1.rsp_valid, 1);
  endtask

  logic exp_err13;
  int   lat;
  int   sent;
  int   cyc;
  logic acc;

  initial begin
`ifdef ALU_DRV_CHECK_EN
    exp_err13 = 1'b1;
`else
    exp_err13 = 1'b0;
`endif
    bus1.cmd_valid = 1'b0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.cmd_sel = '0;
    bus1.cmd_exp = '0; bus1.rsp_ready = 1'b1;
    bus3.cmd_valid = 1'b0; bus3.cmd_a = '0; bus3.cmd_b = '0; bus3.cmd_sel = '0;
    bus3.cmd_exp = '0; bus3.rsp_ready = 1'b1;

    // Reset held with random inputs.
    repeat (4) begin
      bus1.cmd_valid = 1'($urandom); bus1.cmd_a = 4'($urandom); bus1.cmd_b = 4'($urandom);
      bus1.cmd_sel = 3'($urandom); bus1.cmd_exp = 5'($urandom);
      bus1.rsp_ready = 1'($urandom);
      bus3.cmd_valid = 1'($urandom); bus3.cmd_a = 4'($urandom);
      step();
    end
    bus1.cmd_valid = 1'b0; bus1.rsp_ready = 1'b1; bus3.cmd_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Asynchronous reset in the middle of DRIVE.
    send1(4'd3, 4'd4, 3'd2, 5'd0);
    step();
    chk("mid_in_drive_alu_a", alu_a1, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", bus1.rsp_valid, 0);
    chk("mid_rst_cmd_ready", bus1.cmd_ready, 1);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_op_count", opc1, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("mid_rst_after_busy", busy1, 0);
    chk("mid_rst_after_valid", bus1.rsp_valid, 0);

    // Single op, SETTLE=1: 5 + 7.
    send1(4'd5, 4'd7, 3'd0, 5'd12);
    chk("single_alu_a_e0", alu_a1, 0);
    step();
    chk("single_alu_a_e1", alu_a1, 5);
    chk("single_alu_b_e1", alu_b1, 7);
    chk("single_alu_sel_e1", alu_sel1, 0);
    chk("single_valid_e1", bus1.rsp_valid, 0);
    step();
    chk("single_valid_e2", bus1.rsp_valid, 1);
    chk("single_data_e2", bus1.rsp_data, 5'b01100);
    chk("single_sel_e2", bus1.rsp_sel, 0);
    chk("single_opc_e2", opc1, 0);
    step();
    chk("single_opc_e3", opc1, 1);
    chk("single_valid_e3", bus1.rsp_valid, 0);
    chk("single_busy_e3", busy1, 0);

    // Backpressure: 6 back-to-back offers, 5 fit (4 queued + 1 in flight).
    bus1.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus1.cmd_a     = 4'(i + 1);
      bus1.cmd_b     = 4'(2 * i + 3);
      bus1.cmd_sel   = 3'(i + 1);
      bus1.cmd_exp   = 5'($urandom);
      bus1.cmd_valid = 1'b1;
      chk($sformatf("bp_ready_%0d", i), bus1.cmd_ready, (i < 5) ? 1 : 0);
      step();
    end
    bus1.cmd_valid = 1'b0;
    repeat (4) step();
    // First op: 1 - 3 in 5 bits.
    chk("bp_hold_valid", bus1.rsp_valid, 1);
    chk("bp_hold_data", bus1.rsp_data, 5'h1e);
    chk("bp_hold_sel", bus1.rsp_sel, 1);
    chk("bp_full_ready", bus1.cmd_ready, 0);
    chk("bp_busy", busy1, 1);
    bus1.rsp_ready = 1'b1;
    cyc = 0;
    while (busy1 && cyc < 60) begin
      step();
      cyc++;
    end
    chk("bp_drain_busy", busy1, 0);
    chk("bp_op_count", opc1, 6);
    chk("bp_model_empty", mq.size(), 0);

    // SETTLE=3 instance: 7 + 5, response exactly 4 cycles after accept.
    bus3.cmd_a = 4'd7; bus3.cmd_b = 4'd5; bus3.cmd_sel = 3'd0; bus3.cmd_valid = 1'b1;
    step();
    bus3.cmd_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      step();
      if (bus3.rsp_valid) begin
        lat = k;
      end else begin
        chk("s3_alu_a_hold", alu_a3, 7);
        chk("s3_alu_b_hold", alu_b3, 5);
        chk("s3_alu_sel_hold", alu_sel3, 0);
      end
    end
    chk("s3_latency", lat, 4);
    chk("s3_data", bus3.rsp_data, 12);
    chk("s3_sel", bus3.rsp_sel, 0);
    step();
    chk("s3_op_count", opc3, 1);
    chk("s3_valid_clear", bus3.rsp_valid, 0);

    // Expected-value check.
    bus1.rsp_ready = 1'b0;
    send1(4'd5, 4'd7, 3'd0, 5'd12);
    wait_rsp1("chk12_wait");
    chk("chk12_err", bus1.rsp_err, 0);
    bus1.rsp_ready = 1'b1;
    step();
    chk("chk12_err_after", bus1.rsp_err, 0);
    bus1.rsp_ready = 1'b0;
    send1(4'd5, 4'd7, 3'd0, 5'd13);
    wait_rsp1("chk13_wait");
    chk("chk13_err", bus1.rsp_err, exp_err13);
    step();
    chk("chk13_err_held", bus1.rsp_err, exp_err13);
    bus1.rsp_ready = 1'b1;
    step();
    chk("chk13_err_after", bus1.rsp_err, 0);
    chk("chk13_valid_after", bus1.rsp_valid, 0);
    chk("chk_op_count", opc1, 8);

    // op_count wrap: reset, then 256 ops with rsp_ready held high.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    sent = 0;
    cyc  = 0;
    while ((sent < 256 || busy1) && cyc < 3000) begin
      if (sent < 256) begin
        bus1.cmd_valid = 1'b1;
        bus1.cmd_a     = 4'($urandom);
        bus1.cmd_b     = 4'($urandom);
        bus1.cmd_sel   = 3'($urandom);
        bus1.cmd_exp   = 5'($urandom);
      end else begin
        bus1.cmd_valid = 1'b0;
      end
      acc = bus1.cmd_valid && bus1.cmd_ready;
      step();
      cyc++;
      if (acc) sent++;
    end
    bus1.cmd_valid = 1'b0;
    chk("wrap_done_in_time", (cyc < 3000), 1);
    chk("wrap_op_count", opc1, 0);
    chk("wrap_busy", busy1, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
